// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register block.
// Defines the FSM states, register file geometry, Avalon map and status bit positions.
package i2c_tgt_pkg;
  localparam int REG_DEPTH = 16;
  localparam int PTR_W = 4;

  localparam logic [4:0] AV_OWN_ADDR = 5'd16;
  localparam logic [4:0] AV_STATUS   = 5'd17;

  localparam int ST_BUSY     = 0;
  localparam int ST_WR_FLAG  = 1;
  localparam int ST_ADDR_HIT = 2;
  localparam int ST_GC_HIT   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_tgt_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample debounce for one I2C line (FILTER_LEN >= 2).
// Filtered level and one-cycle rise/fall pulses appear 2+FILTER_LEN cycles after the pin settles.
module i2c_tgt_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic                  s1, s2;
  logic [FILTER_LEN-2:0] hist;
  logic                  stable;

  assign stable = (hist == {(FILTER_LEN-1){s2}});

  // Lines idle high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      hist <= '1;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= line;
      s2   <= s1;
      hist <= (FILTER_LEN-1)'({hist, s2});
      rise <= 1'b0;
      fall <= 1'b0;
      if (stable && (s2 != lvl)) begin
        lvl  <= s2;
        rise <= s2;
        fall <= ~s2;
      end
    end
  end
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a 16-byte register file behind an Avalon-MM slave; readdata has 1-cycle latency, SCL is never stretched.
// Define I2C_TGT_GEN_CALL_EN to also ACK general-call (7'h00) writes and report gc_hit in status bit 3.
module i2c_target_regs
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR   = 7'h48,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       scl,
  inout  wire        sda
);
  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic              first, first_nxt;
  logic              sda_oe, sda_oe_nxt;
  logic              rx_done, rx_done_nxt;
  logic              i2c_wr, hit_set, gc_set;
  logic [7:0]        regs [REG_DEPTH];
  logic [6:0]        own_addr;
  logic              wr_flag, addr_hit, gc_hit;
  logic [7:0]        status;
  logic              scl_f, scl_rise, scl_fall;
  logic              sda_f, sda_rise, sda_fall;
  logic              start_det, stop_det, own_match, gc_match, av_wr;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  i2c_tgt_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .line(scl), .lvl(scl_f), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_tgt_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .line(sda), .lvl(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_f;
  assign stop_det  = sda_rise & scl_f;
  assign own_match = (shreg[7:1] == own_addr);
`ifdef I2C_TGT_GEN_CALL_EN
  assign gc_match  = (shreg == 8'h00);
`else
  assign gc_match  = 1'b0;
`endif
  assign av_wr = chipselect & ~write_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      first   <= 1'b0;
      sda_oe  <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      first   <= first_nxt;
      sda_oe  <= sda_oe_nxt;
      rx_done <= rx_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    first_nxt   = first;
    sda_oe_nxt  = sda_oe;
    rx_done_nxt = 1'b0;
    i2c_wr      = 1'b0;
    hit_set     = 1'b0;
    gc_set      = 1'b0;

    // A received byte is complete one cycle after its 8th SCL rise.
    if (rx_done) begin
      if (first) begin
        ptr_nxt   = shreg[PTR_W-1:0];
        first_nxt = 1'b0;
      end else begin
        i2c_wr  = 1'b1;
        ptr_nxt = ptr + PTR_W'(1);
      end
    end

    if (start_det) begin
      state_nxt   = S_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt  = S_IDLE;
      sda_oe_nxt = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (own_match || gc_match) begin
              state_nxt  = S_ADDR_ACK;
              sda_oe_nxt = 1'b1;
              hit_set    = own_match;
              gc_set     = gc_match;
            end else begin
              state_nxt = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (shreg[0]) begin
              // This fall both ends the ACK and presents data bit 7.
              state_nxt   = S_TX_BYTE;
              shreg_nxt   = regs[ptr];
              sda_oe_nxt  = ~regs[ptr][7];
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt   = S_RX_BYTE;
              sda_oe_nxt  = 1'b0;
              first_nxt   = 1'b1;
              bit_cnt_nxt = '0;
            end
          end
        end
        S_RX_BYTE: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
            rx_done_nxt = (bit_cnt == 4'd7);
          end else if (scl_fall && bit_cnt == 4'd8) begin
            state_nxt  = S_RX_ACK;
            sda_oe_nxt = 1'b1;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            state_nxt   = S_RX_BYTE;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = '0;
          end
        end
        S_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_nxt  = S_TX_ACK;
              sda_oe_nxt = 1'b0;
              ptr_nxt    = ptr + PTR_W'(1);
            end else begin
              sda_oe_nxt  = ~shreg[~bit_cnt[2:0]];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              state_nxt   = S_TX_BYTE;
              shreg_nxt   = regs[ptr];
              bit_cnt_nxt = '0;
            end else begin
              state_nxt = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // I2C writes and flag sets come after CPU writes/clears so they win on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
      own_addr <= TGT_ADDR;
      wr_flag  <= 1'b0;
      addr_hit <= 1'b0;
      gc_hit   <= 1'b0;
    end else begin
      if (av_wr && !address[4]) regs[address[3:0]] <= writedata;
      if (av_wr && address == AV_OWN_ADDR) own_addr <= writedata[6:0];
      if (av_wr && address == AV_STATUS) begin
        if (writedata[ST_WR_FLAG])  wr_flag  <= 1'b0;
        if (writedata[ST_ADDR_HIT]) addr_hit <= 1'b0;
        if (writedata[ST_GC_HIT])   gc_hit   <= 1'b0;
      end
      if (i2c_wr) begin
        regs[ptr] <= shreg;
        wr_flag   <= 1'b1;
      end
      if (hit_set) addr_hit <= 1'b1;
      if (gc_set)  gc_hit   <= 1'b1;
    end
  end

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = (state != S_IDLE);
    status[ST_WR_FLAG]  = wr_flag;
    status[ST_ADDR_HIT] = addr_hit;
    status[ST_GC_HIT]   = gc_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && write_n) begin
      if (!address[4])                readdata <= regs[address[3:0]];
      else if (address == AV_OWN_ADDR) readdata <= {1'b0, own_addr};
      else if (address == AV_STATUS)   readdata <= status;
      else                             readdata <= '0;
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-level I2C master plus Avalon driver; expected values queued in a scoreboard.
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       scl;
  logic       m_sda;
  wire        sda;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target_regs #(.TGT_ADDR(7'h48), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl(scl), .sda(sda)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic       r;
  logic [7:0] d;

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    tests++;
    if (exp_q.size() == 0) begin
      e = 'x;
      t = "scoreboard_empty";
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
    end
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", t, obs, e);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic av_write(input logic [4:0] a, input logic [7:0] v);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = v;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    v = readdata;
    chipselect = 1'b0;
  endtask

  task automatic av_check(input string tag, input logic [4:0] a, input logic [7:0] e);
    logic [7:0] v;
    expect_val(tag, e);
    av_read(a, v);
    observe(v);
  endtask

  task automatic bit_xfer(input logic b, output logic rb);
    m_sda = b; wq();
    scl = 1'b1; wq();
    rb = sda; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b, input logic exp_ack);
    logic rb;
    expect_val(tag, {7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], rb);
    bit_xfer(1'b1, rb);
    observe({7'b0, rb});
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] e, input logic nack);
    logic [7:0] v;
    logic       rb;
    expect_val(tag, e);
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, rb);
      v[i] = rb;
    end
    observe(v);
    bit_xfer(nack, rb);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    expect_val("reset_readdata", 8'h00); observe(readdata);
    expect_val("reset_sda", 8'h01); observe({7'b0, sda});
    reset = 1'b0;
    repeat (4) @(negedge clk);
    av_check("reset_status", 5'd17, 8'h00);
    av_check("reset_own_addr", 5'd16, 8'h48);
    av_check("reset_reg3", 5'd3, 8'h00);

    // Write 0xA5, 0x3C starting at register 5
    i2c_start();
    wr_byte("t1_addr_ack", 8'h90, 1'b0);
    wr_byte("t1_ptr_ack", 8'h05, 1'b0);
    wr_byte("t1_d0_ack", 8'hA5, 1'b0);
    wr_byte("t1_d1_ack", 8'h3C, 1'b0);
    i2c_stop(); wq();
    av_check("t1_reg5", 5'd5, 8'hA5);
    av_check("t1_reg6", 5'd6, 8'h3C);
    av_check("t1_status", 5'd17, 8'h06);
    av_write(5'd17, 8'h0E);
    av_check("status_cleared", 5'd17, 8'h00);

    // Wrong address is not acknowledged
    i2c_start();
    wr_byte("t3_nack", 8'h92, 1'b1);
    i2c_stop(); wq();
    av_check("t3_reg5", 5'd5, 8'hA5);
    av_check("t3_status", 5'd17, 8'h00);

    // Read across the 15 -> 0 pointer wrap
    av_write(5'd15, 8'h11);
    av_write(5'd0, 8'h22);
    i2c_start();
    wr_byte("t2_addr_w_ack", 8'h90, 1'b0);
    wr_byte("t2_ptr_ack", 8'h0F, 1'b0);
    i2c_start();
    wr_byte("t2_addr_r_ack", 8'h91, 1'b0);
    rd_byte("t2_rd0", 8'h11, 1'b0);
    rd_byte("t2_rd1_wrap", 8'h22, 1'b1);
    expect_val("t2_sda_released", 8'h01); observe({7'b0, sda});
    av_check("t2_status_wait_stop", 5'd17, 8'h05);
    i2c_stop(); wq();
    av_check("t2_status_idle", 5'd17, 8'h04);

    // Reprogrammed own address
    av_write(5'd16, 8'h2A);
    i2c_start();
    wr_byte("t4_new_addr_ack", 8'h54, 1'b0);
    i2c_stop(); wq();
    i2c_start();
    wr_byte("t4_old_addr_nack", 8'h90, 1'b1);
    i2c_stop(); wq();
    av_check("t4_own_addr", 5'd16, 8'h2A);
    av_write(5'd16, 8'h48);
    av_check("unmapped_reads_zero", 5'd20, 8'h00);

    // One-cycle SDA glitches while SCL is high are filtered out
    av_write(5'd17, 8'h0E);
    m_sda = 1'b0; @(negedge clk); m_sda = 1'b1;
    wq(); wq();
    av_check("t6_idle_glitch", 5'd17, 8'h00);
    i2c_start();
    wr_byte("t6_addr_ack", 8'h90, 1'b0);
    m_sda = 1'b0; wq();
    scl = 1'b1; repeat (4) @(negedge clk);
    m_sda = 1'b1; @(negedge clk); m_sda = 1'b0;
    repeat (3) @(negedge clk);
    scl = 1'b0; wq();
    for (int i = 0; i < 7; i++) bit_xfer(1'b0, r);
    expect_val("t6_ptr_ack_after_glitch", 8'h00);
    bit_xfer(1'b1, r);
    observe({7'b0, r});
    av_check("t6_busy", 5'd17, 8'h05);
    wr_byte("t6_data_ack", 8'h5A, 1'b0);
    i2c_stop(); wq();
    av_check("t6_reg0", 5'd0, 8'h5A);

    // Reset in the middle of a transmitted byte
    av_write(5'd0, 8'h00);
    av_check("t5_pre_readdata", 5'd16, 8'h48);
    i2c_start();
    wr_byte("t5_addr_w_ack", 8'h90, 1'b0);
    wr_byte("t5_ptr_ack", 8'h00, 1'b0);
    i2c_start();
    wr_byte("t5_addr_r_ack", 8'h91, 1'b0);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    m_sda = 1'b1; wq();
    scl = 1'b1; wq();
    expect_val("t5_driving_bit4", 8'h00); observe({7'b0, sda});
    reset = 1'b1;
    @(negedge clk);
    expect_val("t5_sda_released", 8'h01); observe({7'b0, sda});
    expect_val("t5_readdata_reset", 8'h00); observe(readdata);
    reset = 1'b0;
    scl = 1'b0; wq();
    i2c_start();
    wr_byte("t5_post_addr_ack", 8'h90, 1'b0);
    wr_byte("t5_post_ptr_ack", 8'h01, 1'b0);
    wr_byte("t5_post_data_ack", 8'h77, 1'b0);
    i2c_stop(); wq();
    av_check("t5_reg1", 5'd1, 8'h77);
    av_check("t5_reg5_cleared", 5'd5, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
